// File: rtl/accel_mem_request_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : accel_mem_request_encoder                                    |
// | Description : Avalon-MM master that buffers load/store requests in a small |
// |               FIFO, issues them one at a time as a packed 128-bit command  |
// |               word, and returns size-masked load data / store completions. |
// |               Optional macro ACCEL_MEM_ALIGN_CHECK_EN rejects misaligned   |
// |               requests locally and adds the rsp_err output.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module accel_mem_request_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int FIFO_AW    = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [30:0]  req_addr,
  input  logic [63:0]  req_wdata,
  input  logic [1:0]   req_size,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_write,
  output logic [63:0]  rsp_rdata,
`ifdef ACCEL_MEM_ALIGN_CHECK_EN
  output logic         rsp_err,
`endif
  output logic         avm_address,
  output logic         avm_read,
  output logic         avm_write,
  output logic [127:0] avm_writedata,
  input  logic [127:0] avm_readdata,
  input  logic         avm_waitrequest
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // FIFO entry layout: {write, size[1:0], addr[30:0], wdata[63:0]}
  localparam int               c_ENTRY_W  = 98;
  localparam logic [FIFO_AW:0] c_FULL_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

  // Command word as consumed by the bridge; size flags are one-hot except 32b.
  function automatic logic [127:0] pack_cmd(input logic wr, input logic [30:0] addr,
                                            input logic [63:0] wdata, input logic [1:0] size);
    logic [127:0] word;
    word        = '0;
    word[30:0]  = addr;
    word[95:32] = wr ? wdata : 64'd0;
    word[96]    = (size == 2'd0);
    word[97]    = (size == 2'd1);
    word[98]    = (size == 2'd3);
    return word;
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    logic [63:0] m;
    case (size)
      2'd0:    m = 64'h0000_0000_0000_00FF;
      2'd1:    m = 64'h0000_0000_0000_FFFF;
      2'd2:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

  // FIFO state
  logic [c_ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]     count_q;
  logic [FIFO_AW:0]     w_count_d;
  logic                 req_ready_q;
  logic                 w_push, w_pop;

  // Transaction / response state
  state_t        state_q, state_d;
  logic          avm_read_q, avm_read_d;
  logic          avm_write_q, avm_write_d;
  logic [127:0]  avm_wdata_q, avm_wdata_d;
  logic [1:0]    size_q, size_d;
  logic          rsp_write_q, rsp_write_d;
  logic [63:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  // Head-of-FIFO fields
  logic [c_ENTRY_W-1:0] w_head;
  logic                 w_head_write;
  logic [1:0]           w_head_size;
  logic [30:0]          w_head_addr;
  logic [63:0]          w_head_wdata;
  logic                 w_not_empty;
  logic                 w_misaligned;
  logic                 unused_rdata_hi;

  assign w_head       = fifo_mem_q[rd_ptr_q];
  assign w_head_write = w_head[97];
  assign w_head_size  = w_head[96:95];
  assign w_head_addr  = w_head[94:64];
  assign w_head_wdata = w_head[63:0];
  assign w_not_empty  = (count_q != '0);
  assign w_push       = req_valid && req_ready_q;

`ifdef ACCEL_MEM_ALIGN_CHECK_EN
  assign w_misaligned = ((w_head_size == 2'd1) && (w_head_addr[0]   != 1'b0))  ||
                        ((w_head_size == 2'd2) && (w_head_addr[1:0] != 2'b00)) ||
                        ((w_head_size == 2'd3) && (w_head_addr[2:0] != 3'b000));
  assign rsp_err      = rsp_err_q;
`else
  assign w_misaligned = 1'b0;
`endif

  assign unused_rdata_hi = ^{avm_readdata[127:64], w_misaligned, rsp_err_q};

  assign req_ready     = req_ready_q;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign avm_address   = 1'b0;
  assign avm_read      = avm_read_q;
  assign avm_write     = avm_write_q;
  assign avm_writedata = avm_wdata_q;

  // Occupancy update; push and pop together leave the count unchanged.
  always_comb begin
    w_count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   w_count_d = count_q + (FIFO_AW + 1)'(1);
      2'b01:   w_count_d = count_q - (FIFO_AW + 1)'(1);
      default: w_count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy and registered not-full flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      req_ready_q <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      count_q     <= w_count_d;
      req_ready_q <= (w_count_d != c_FULL_CNT);
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (w_push) fifo_mem_q[wr_ptr_q] <= {req_write, req_size, req_addr, req_wdata};
  end

  // Next-state and transaction bookkeeping; a pop happens from IDLE, or from
  // RESP in the same cycle the response is consumed.
  always_comb begin
    state_d     = state_q;
    avm_read_d  = avm_read_q;
    avm_write_d = avm_write_q;
    avm_wdata_d = avm_wdata_q;
    size_d      = size_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    w_pop       = 1'b0;
    case (state_q)
      IDLE: w_pop = w_not_empty;
      BUS: begin
        if (!avm_waitrequest) begin
          avm_read_d  = 1'b0;
          avm_write_d = 1'b0;
          rsp_write_d = avm_write_q;
          rsp_rdata_d = avm_write_q ? 64'd0 : (avm_readdata[63:0] & size_mask(size_q));
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (w_not_empty) w_pop = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (w_pop) begin
      if (w_misaligned) begin
        // Rejected locally: never reaches the bus, answered with an error.
        state_d     = RESP;
        rsp_write_d = w_head_write;
        rsp_rdata_d = 64'd0;
        rsp_err_d   = 1'b1;
      end else begin
        state_d     = BUS;
        avm_read_d  = !w_head_write;
        avm_write_d = w_head_write;
        avm_wdata_d = pack_cmd(w_head_write, w_head_addr, w_head_wdata, w_head_size);
        size_d      = w_head_size;
      end
    end
  end

  // State and transaction registers; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      avm_read_q  <= 1'b0;
      avm_write_q <= 1'b0;
      avm_wdata_q <= '0;
      size_q      <= 2'd0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      avm_read_q  <= avm_read_d;
      avm_write_q <= avm_write_d;
      avm_wdata_q <= avm_wdata_d;
      size_q      <= size_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_accel_mem_request_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_accel_mem_request_encoder                                 |
// | Description : Scoreboard bench: directed scenarios followed by random      |
// |               traffic with random backpressure and bus stalls.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_accel_mem_request_encoder;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_write;
  logic [30:0]  req_addr;
  logic [63:0]  req_wdata;
  logic [1:0]   req_size;
  logic         rsp_valid, rsp_ready, rsp_write;
  logic [63:0]  rsp_rdata;
  logic         avm_address, avm_read, avm_write, avm_waitrequest;
  logic [127:0] avm_writedata, avm_readdata;
`ifdef ACCEL_MEM_ALIGN_CHECK_EN
  logic         rsp_err;
`endif

  logic rand_mode = 1'b0;
  logic rsp_ready_dir = 1'b0, rsp_ready_rnd = 1'b1;
  logic wait_dir = 1'b0, wait_rnd = 1'b0;

  int vecs  = 0;
  int fails = 0;
  int cyc   = 0;
  int bus_prev_cyc = 0, bus_last_cyc = 0;

  logic [129:0] cmd_q [$];   // {read, write, word}
  logic [65:0]  rsp_q [$];   // {err, write, rdata}

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents seen by loads: a fixed pattern per address.
  function automatic logic [63:0] mem_data(input logic [30:0] a);
    if (a == 31'h100) return 64'h1122_3344_5566_7788;
    return {1'b0, a, 32'h0} ^ (64'(a) * 64'h9E37_79B9_7F4A_7C15) ^ 64'hA5A5_0F0F_3C3C_F00D;
  endfunction

  function automatic logic [63:0] mask_of(input logic [1:0] s);
    if (s == 2'd3) return {64{1'b1}};
    return (64'd1 << (8 << s)) - 64'd1;
  endfunction

  function automatic logic [127:0] exp_word(input logic w, input logic [30:0] a,
                                            input logic [63:0] d, input logic [1:0] s);
    logic [127:0] x;
    x = 128'(a) + ((w ? 128'(d) : 128'd0) << 32);
    if (s == 2'd0) x = x + (128'd1 << 96);
    if (s == 2'd1) x = x + (128'd1 << 97);
    if (s == 2'd3) x = x + (128'd1 << 98);
    return x;
  endfunction

  assign rsp_ready       = rand_mode ? rsp_ready_rnd : rsp_ready_dir;
  assign avm_waitrequest = rand_mode ? wait_rnd : wait_dir;
  assign avm_readdata    = {64'hFEED_FACE_CAFE_BEEF, mem_data(avm_writedata[30:0])};

  accel_mem_request_encoder #(.FIFO_DEPTH(2), .FIFO_AW(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
`ifdef ACCEL_MEM_ALIGN_CHECK_EN
    .rsp_err(rsp_err),
`endif
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: what an accepted request must produce on bus and response.
  task automatic model_accept(input logic w, input logic [30:0] a,
                              input logic [63:0] d, input logic [1:0] s);
    logic bad;
    bad = 1'b0;
`ifdef ACCEL_MEM_ALIGN_CHECK_EN
    bad = ((32'(a) % (32'd1 << s)) != 0);
`endif
    if (bad) begin
      rsp_q.push_back({1'b1, w, 64'd0});
    end else begin
      cmd_q.push_back({!w, w, exp_word(w, a, d, s)});
      rsp_q.push_back({1'b0, w, w ? 64'd0 : (mem_data(a) & mask_of(s))});
    end
  endtask

  // Presents one request, holds it until accepted; returns just after the accepting edge.
  task automatic send(input logic w, input logic [30:0] a, input logic [63:0] d, input logic [1:0] s);
    int t;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_size = s;
    t = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      t++;
      if (t > 200) begin
        check("req_accept_timeout", {127'd0, req_ready}, 128'd1);
        break;
      end
    end
    if (req_ready) model_accept(w, a, d, s);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((rsp_q.size() != 0 || cmd_q.size() != 0) && t < 500) begin
      step();
      t++;
    end
    check("drain_left", 128'(rsp_q.size() + cmd_q.size()), 128'd0);
  endtask

  // Random backpressure and bus stalls.
  always @(posedge clk) begin
    #1;
    rsp_ready_rnd = ($urandom_range(3) != 0);
    wait_rnd      = ($urandom_range(2) == 0);
  end

  // Monitor: compares every completed bus transfer and every consumed response.
  logic         hold_chk = 1'b0;
  logic [129:0] hold_val;
  always @(negedge clk) begin
    logic [129:0] ec;
    logic [65:0]  er;
    if (reset) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) check("bus_hold", {avm_read, avm_write, avm_writedata}, hold_val);
      if (avm_read || avm_write) begin
        check("rw_exclusive", {127'd0, avm_read & avm_write}, 128'd0);
        check("avm_address", {127'd0, avm_address}, 128'd0);
      end
      if ((avm_read || avm_write) && !avm_waitrequest) begin
        bus_prev_cyc = bus_last_cyc;
        bus_last_cyc = cyc;
        if (cmd_q.size() == 0) begin
          check("bus_unexpected", {126'd0, avm_read, avm_write}, 128'd0);
        end else begin
          ec = cmd_q.pop_front();
          check("bus_cmd_rw", {126'd0, avm_read, avm_write}, {126'd0, ec[129:128]});
          check("bus_cmd_word", avm_writedata, ec[127:0]);
        end
      end
      hold_chk = (avm_read || avm_write) && avm_waitrequest;
      hold_val = {avm_read, avm_write, avm_writedata};
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", {127'd0, rsp_valid}, 128'd0);
        end else begin
          er = rsp_q.pop_front();
          check("rsp_write", {127'd0, rsp_write}, {127'd0, er[64]});
          check("rsp_rdata", {64'd0, rsp_rdata}, {64'd0, er[63:0]});
`ifdef ACCEL_MEM_ALIGN_CHECK_EN
          check("rsp_err", {127'd0, rsp_err}, {127'd0, er[65]});
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_size = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {127'd0, req_ready}, 128'd0);
    check("rst_rsp_valid", {127'd0, rsp_valid}, 128'd0);
    check("rst_rsp_write", {127'd0, rsp_write}, 128'd0);
    check("rst_rsp_rdata", {64'd0, rsp_rdata}, 128'd0);
    check("rst_avm_rw", {126'd0, avm_read, avm_write}, 128'd0);
    check("rst_avm_wdata", avm_writedata, 128'd0);
`ifdef ACCEL_MEM_ALIGN_CHECK_EN
    check("rst_rsp_err", {127'd0, rsp_err}, 128'd0);
`endif
    reset = 1'b0;
    step();
    check("post_rst_ready", {127'd0, req_ready}, 128'd1);

    // 32b load: one bus cycle, response two cycles after the push
    rsp_ready_dir = 1'b1;
    send(1'b0, 31'h100, 64'h0, 2'd2);
    step();
    check("ld32_avm_read", {126'd0, avm_read, rsp_valid}, {126'd0, 2'b10});
    check("ld32_cmd", avm_writedata, 128'h100);
    step();
    check("ld32_done", {126'd0, avm_read, rsp_valid}, {126'd0, 2'b01});
    check("ld32_rdata", {64'd0, rsp_rdata}, 128'h5566_7788);
    step();

    // 8b store
    send(1'b1, 31'h7, 64'hAB, 2'd0);
    step();
    check("st8_avm_write", {126'd0, avm_read, avm_write}, {126'd0, 2'b01});
    check("st8_cmd", avm_writedata, 128'h00000001_00000000000000AB_00000007);
    step();
    check("st8_rsp", {62'd0, rsp_valid, rsp_write, rsp_rdata}, {62'd0, 2'b11, 64'd0});
    step();

    // 64b load stalled for 5 cycles
    wait_dir = 1'b1;
    send(1'b0, 31'h200, 64'h0, 2'd3);
    n = 0;
    for (int t = 0; t < 20 && !avm_read; t++) step();
    if (avm_read) n = 1;
    repeat (4) begin step(); if (avm_read) n++; end
    step();
    if (avm_read) n++;
    wait_dir = 1'b0;
    step();
    check("stall_read_cycles", 128'(n), 128'd6);
    check("stall_done", {126'd0, avm_read, rsp_valid}, {126'd0, 2'b01});
    check("stall_rdata", {64'd0, rsp_rdata}, {64'd0, mem_data(31'h200)});
    step();

    // Fill the FIFO behind a blocked response, then drain in order
    rsp_ready_dir = 1'b0;
    send(1'b0, 31'h10, 64'h0, 2'd2);
    send(1'b0, 31'h20, 64'h0, 2'd2);
    send(1'b0, 31'h30, 64'h0, 2'd2);
    check("fifo_full_ready", {127'd0, req_ready}, 128'd0);
    repeat (3) step();
    check("fifo_full_hold", {126'd0, req_ready, rsp_valid}, {126'd0, 2'b01});
    rsp_ready_dir = 1'b1;
    drain();
    check("drain_spacing", 128'(bus_last_cyc - bus_prev_cyc), 128'd2);

    // Reset while a stalled load is on the bus
    wait_dir = 1'b1;
    send(1'b0, 31'h300, 64'h0, 2'd3);
    for (int t = 0; t < 20 && !avm_read; t++) step();
    check("rst_mid_inflight", {127'd0, avm_read}, 128'd1);
    reset = 1'b1;
    cmd_q.delete();
    rsp_q.delete();
    step();
    check("rst_mid_outputs", {125'd0, avm_read, rsp_valid, req_ready}, 128'd0);
    reset = 1'b0;
    wait_dir = 1'b0;
    step();
    check("rst_mid_ready", {127'd0, req_ready}, 128'd1);
    repeat (10) step();
    check("rst_mid_no_stale", {126'd0, rsp_valid, avm_read}, 128'd0);

    // Random traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(2)) step();
      send(1'($urandom_range(1)), 31'($urandom), {$urandom, $urandom}, 2'($urandom_range(3)));
    end
    rand_mode = 1'b0;
    rsp_ready_dir = 1'b1;
    wait_dir = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
`default_nettype wire
